// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the fetch/decode/execute/memory/writeback datapath.
// Owns the shared memory handshake, all datapath enables, halt/error status and perf counters.
module multicycle_controller #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic        memtoreg,
    output logic        halted,
    output logic        error,
    output logic [31:0] cycle_count,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH
    } cls_t;

    localparam logic [6:0] OP_R_ALU  = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_HALT   = 7'b1111111;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic        cls_ld;
    logic        err_q, err_set;
    logic [7:0]  wait_q;
    logic        wait_inc;
    logic        retire;
    logic        in_run;
    logic [31:0] cyc_q, ret_q;

    assign in_run = (state_q != S_IDLE) && (state_q != S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            wait_q  <= 8'd0;
            cyc_q   <= 32'd0;
            ret_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (err_set)
                err_q <= 1'b1;
            // The wait counter restarts whenever a new state (and so a new request) begins.
            if (state_d != state_q)
                wait_q <= 8'd0;
            else if (wait_inc)
                wait_q <= wait_q + 8'd1;
            if (in_run)
                cyc_q <= cyc_q + 32'd1;
            if (retire)
                ret_q <= ret_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (cls_ld)
            cls_q <= cls_d;
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = C_ALU;
        cls_ld       = 1'b0;
        err_set      = 1'b0;
        wait_inc     = 1'b0;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        reg_we       = 1'b0;
        memtoreg     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (start)
                        state_d = S_FETCH;
                end
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        err_set = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                S_DECODE: begin
                    cls_ld  = 1'b1;
                    state_d = S_EXECUTE;
                    case (opcode)
                        OP_R_ALU, OP_I_ALU: cls_d = C_ALU;
                        OP_LOAD:            cls_d = C_LOAD;
                        OP_STORE:           cls_d = C_STORE;
                        OP_BRANCH:          cls_d = C_BRANCH;
                        OP_HALT:            state_d = S_HALT;
                        default: begin
                            err_set = 1'b1;
                            state_d = S_HALT;
                        end
                    endcase
                end
                S_EXECUTE: begin
                    case (cls_q)
                        C_ALU:   state_d = S_WRITEBACK;
                        C_BRANCH: begin
                            pc_we   = 1'b1;
                            pc_src  = branch_taken;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        default: state_d = S_MEMORY;
                    endcase
                end
                S_MEMORY: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls_q == C_STORE);
                    if (mem_ready) begin
                        if (cls_q == C_STORE) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WRITEBACK;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        err_set = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    reg_we   = 1'b1;
                    memtoreg = (cls_q == C_LOAD);
                    pc_we    = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status and counters read as zero for the whole cycle in which rst is held.
    assign halted      = !rst && (state_q == S_HALT);
    assign error       = !rst && err_q;
    assign cycle_count = rst ? 32'd0 : cyc_q;
    assign instret     = rst ? 32'd0 : ret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model expands each
// planned instruction into its expected per-cycle control trace and latency.
module tb_multicycle_controller;

    localparam int MAXW = 15;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3;

    // Control vector: {halted, error, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, memtoreg}
    localparam logic [9:0] V_HALTED = 10'h200;
    localparam logic [9:0] V_ERROR  = 10'h100;
    localparam logic [9:0] V_REQ    = 10'h080;
    localparam logic [9:0] V_WE     = 10'h040;
    localparam logic [9:0] V_SEL    = 10'h020;
    localparam logic [9:0] V_IR     = 10'h010;
    localparam logic [9:0] V_PCWE   = 10'h008;
    localparam logic [9:0] V_PCSRC  = 10'h004;
    localparam logic [9:0] V_REGWE  = 10'h002;
    localparam logic [9:0] V_MTR    = 10'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, memtoreg;
    logic        halted, error;
    logic [31:0] cycle_count, instret;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cyc_exp = 0;
    logic [31:0] ins_exp = 0;

    multicycle_controller #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .memtoreg(memtoreg), .halted(halted), .error(error),
        .cycle_count(cycle_count), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl();
        return {halted, error, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, memtoreg};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".cycles"}, 64'(cycle_count), 64'(cyc_exp));
        check({tag, ".instret"}, 64'(instret), 64'(ins_exp));
    endtask

    // One clock: drive inputs on the falling edge, compare the combinational controls, then clock.
    task automatic step(input string tag, input logic rdy, input logic [6:0] opc,
                        input logic bt, input logic [9:0] exp);
        @(negedge clk);
        mem_ready = rdy;
        opcode = opc;
        branch_taken = bt;
        #1;
        check(tag, 64'(ctrl()), 64'(exp));
        @(posedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        #1;
        check("idle", 64'(ctrl()), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("rst.ctrl", 64'(ctrl()), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc_exp = 0;
        ins_exp = 0;
        #1;
        check("rst.after", 64'(ctrl()), 64'd0);
        check_counters("rst");
    endtask

    function automatic logic [6:0] opcode_of(input int kind);
        case (kind)
            K_ALU:   return ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
            K_LOAD:  return 7'b0000011;
            K_STORE: return 7'b0100011;
            default: return 7'b1100011;
        endcase
    endfunction

    task automatic fetch(input int fw);
        for (int i = 0; i < fw; i++)
            step("fetch.wait", 1'b0, 7'($urandom), 1'($urandom), V_REQ);
        step("fetch.done", 1'b1, 7'($urandom), 1'($urandom), V_REQ | V_IR);
    endtask

    // Expected trace for one instruction; latency from FETCH entry is base + waits.
    task automatic run_instr(input int kind, input logic taken, input int fw, input int mw);
        logic [6:0] opc;
        logic [9:0] mv;
        int lat;
        opc = opcode_of(kind);
        fetch(fw);
        step("decode", 1'($urandom), opc, 1'($urandom), 10'd0);
        if (kind == K_BRANCH)
            step("exec.br", 1'($urandom), opc, taken, V_PCWE | (taken ? V_PCSRC : 10'd0));
        else
            step("exec", 1'($urandom), opc, 1'($urandom), 10'd0);
        if (kind == K_LOAD || kind == K_STORE) begin
            mv = V_REQ | V_SEL | ((kind == K_STORE) ? V_WE : 10'd0);
            for (int i = 0; i < mw; i++)
                step("mem.wait", 1'b0, opc, 1'($urandom), mv);
            step("mem.done", 1'b1, opc, 1'($urandom), mv | ((kind == K_STORE) ? V_PCWE : 10'd0));
        end
        if (kind == K_ALU || kind == K_LOAD)
            step("wb", 1'($urandom), opc, 1'($urandom),
                 V_REGWE | V_PCWE | ((kind == K_LOAD) ? V_MTR : 10'd0));
        case (kind)
            K_BRANCH: lat = 3;
            K_LOAD:   lat = 5;
            default:  lat = 4;
        endcase
        if (kind == K_LOAD || kind == K_STORE)
            lat += mw;
        lat += fw;
        cyc_exp += 32'(lat);
        ins_exp += 1;
        #1;
        check_counters("instr");
    endtask

    task automatic halt_op(input logic [6:0] opc, input logic is_err);
        fetch(0);
        step("decode.halt", 1'b0, opc, 1'b0, 10'd0);
        cyc_exp += 2;
        #1;
        check("halt.state", 64'(ctrl()), 64'(V_HALTED | (is_err ? V_ERROR : 10'd0)));
        check_counters("halt");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset.ctrl", 64'(ctrl()), 64'd0);
        check_counters("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset.idle", 64'(ctrl()), 64'd0);

        do_start();
        run_instr(K_ALU, 1'b0, 0, 0);
        run_instr(K_LOAD, 1'b0, 0, 2);
        run_instr(K_BRANCH, 1'b1, 0, 0);
        run_instr(K_BRANCH, 1'b0, 0, 0);
        for (int n = 0; n < 60; n++)
            run_instr($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        run_instr(K_STORE, 1'b0, 1, 1);
        halt_op(7'b1111111, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            mem_ready = 1'($urandom);
            #1;
            check("halt.frozen", 64'(ctrl()), 64'(V_HALTED));
            check_counters("halt.frozen");
        end
        start = 1'b0;

        // Fetch timeout after MAX_WAIT cycles without ready.
        do_reset();
        do_start();
        for (int i = 0; i < MAXW; i++)
            step("to.fetch", 1'b0, 7'($urandom), 1'b0, V_REQ);
        cyc_exp += MAXW;
        #1;
        check("to.halt", 64'(ctrl()), 64'(V_HALTED | V_ERROR));
        check_counters("to");

        // Ready on the final allowed cycle succeeds, for both fetch and data access.
        do_reset();
        do_start();
        run_instr(K_ALU, 1'b0, MAXW - 1, 0);
        run_instr(K_LOAD, 1'b0, 0, MAXW - 1);
        check("edge.err", 64'(error), 64'd0);

        // Reset during a STORE's memory wait.
        do_reset();
        do_start();
        fetch(0);
        step("st.decode", 1'b0, 7'b0100011, 1'b0, 10'd0);
        step("st.exec", 1'b0, 7'b0100011, 1'b0, 10'd0);
        step("st.wait", 1'b0, 7'b0100011, 1'b0, V_REQ | V_SEL | V_WE);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.ctrl", 64'(ctrl()), 64'd0);
        check("midrst.instret", 64'(instret), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc_exp = 0;
        ins_exp = 0;
        #1;
        check("midrst.idle", 64'(ctrl()), 64'd0);
        check_counters("midrst");
        do_start();
        run_instr(K_ALU, 1'b0, 0, 0);
        halt_op(7'b1010101, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
